// File: rtl/ram16_delay_pkg.sv
// Shared constants for the RAM16-based programmable delay line.
// Pointer/fill widths, storage depth and the longest supported delay.
// Helper computes the fill level at which the line is full for a given LEN.
package ram16_delay_pkg;

    localparam int PTR_W     = 4;
    localparam int FILL_W    = 5;
    localparam int DEPTH     = 16;
    localparam int MAX_DELAY = 16;

    // Fill level that marks a full line: LEN+1 samples held.
    function automatic logic [FILL_W-1:0] fill_target(input logic [PTR_W-1:0] len);
        return FILL_W'({1'b0, len}) + FILL_W'(1);
    endfunction

endpackage

// File: rtl/ram16_delay_ctrl.sv
// Delay-line control: pointer, fill counter, registered LEN and restart detect.
// Latency: state updates on the CLK rising edge; dv/restart decode combinationally.
// Backpressure: CE=0 freezes all state. Ports: CLK, RESETN, CE, LEN -> ptr, restart, dv.
module ram16_delay_ctrl
    import ram16_delay_pkg::*;
(
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic [PTR_W-1:0] LEN,
    output logic [PTR_W-1:0] ptr,
    output logic             restart,
    output logic             dv
);

    logic [PTR_W-1:0]  len_q,  len_d;
    logic [PTR_W-1:0]  ptr_q,  ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W-1:0] fill_full;

    assign fill_full = fill_target(len_q);
    // Any change of LEN throws away the line contents and refills from empty.
    assign restart   = (LEN != len_q);

    always_comb begin
        len_d  = len_q;
        ptr_d  = ptr_q;
        fill_d = fill_q;
        if (restart) begin
            len_d  = LEN;
            ptr_d  = '0;
            fill_d = '0;
        end else if (CE) begin
            ptr_d  = (ptr_q == len_q) ? '0 : ptr_q + PTR_W'(1);
            fill_d = (fill_q == fill_full) ? fill_q : fill_q + FILL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            len_q  <= '0;
            ptr_q  <= '0;
            fill_q <= '0;
        end else begin
            len_q  <= len_d;
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
        end
    end

    assign ptr = ptr_q;
    assign dv  = (fill_q == fill_full);

endmodule

// File: rtl/ram16s1.sv
// RAM16S1: 16x1 single-port RAM bit slice, combinational read, synchronous write.
// Latency: read is combinational from AD; write lands on the rising CLK edge.
// Backpressure: none; WRE gates the write. Ports: CLK, AD (address), DI, WRE, DO.
module RAM16S1 #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic       CLK,
    input  logic [3:0] AD,
    input  logic       DI,
    input  logic       WRE,
    output logic       DO
);

    // Contents are never reset; they power up at INIT and keep the last write.
    logic [15:0] mem_q = INIT;
    logic [15:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (WRE) begin
            mem_d[AD] = DI;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Read sees the word before this edge's write (read-before-write).
    assign DO = mem_q[AD];

endmodule

// File: rtl/ram16_delay_line.sv
// Programmable delay line of LEN+1 CE cycles (1..16) built from WIDTH RAM16S1 slices.
// Latency: DO = DI from LEN+1 CE cycles back; LEN+2 with RAM16_DELAY_OREG_EN defined.
// Backpressure: CE=0 holds everything. Ports: CLK, RESETN, CE, LEN, DI -> DO, DV.
module ram16_delay_line
    import ram16_delay_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic [PTR_W-1:0] LEN,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DO,
    output logic             DV
);

    logic [PTR_W-1:0] ptr;
    logic             restart;
    logic             base_dv;
    logic             wre;
    logic [WIDTH-1:0] rd_dat;
    logic [WIDTH-1:0] base_dat;

    ram16_delay_ctrl u_ctrl (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .CE      (CE),
        .LEN     (LEN),
        .ptr     (ptr),
        .restart (restart),
        .dv      (base_dv)
    );

    // A restart edge must not disturb memory, whatever CE says.
    assign wre = CE & ~restart;

    for (genvar b = 0; b < WIDTH; b++) begin : g_slice
        RAM16S1 #(
            .INIT ({DEPTH{INIT_VAL[b]}})
        ) u_ram (
            .CLK (CLK),
            .AD  (ptr),
            .DI  (DI[b]),
            .WRE (wre),
            .DO  (rd_dat[b])
        );
    end

    assign base_dat = base_dv ? rd_dat : '0;

`ifdef RAM16_DELAY_OREG_EN
    logic [WIDTH-1:0] do_q, do_d;
    logic             dv_q, dv_d;

    always_comb begin
        do_d = do_q;
        dv_d = dv_q;
        if (restart) begin
            do_d = '0;
            dv_d = 1'b0;
        end else if (CE) begin
            do_d = base_dat;
            dv_d = base_dv;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            do_q <= '0;
            dv_q <= 1'b0;
        end else begin
            do_q <= do_d;
            dv_q <= dv_d;
        end
    end

    assign DV = dv_q;
    assign DO = dv_q ? do_q : '0;
`else
    assign DV = base_dv;
    assign DO = base_dat;
`endif

endmodule

// File: tb/tb_ram16_delay_line.sv
// Self-checking bench for ram16_delay_line (WIDTH=8): directed vectors against a delay model.
// Covers reset, basic delay, CE gaps, full depth wrap, LEN change, async reset, LEN=0.
// Works in both base and RAM16_DELAY_OREG_EN builds via an extra-latency constant.
module tb_ram16_delay_line;

`ifdef RAM16_DELAY_OREG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       CE;
    logic [3:0] LEN;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       DV;

    ram16_delay_line #(.WIDTH(8), .INIT_VAL(8'h00)) u_dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .CE     (CE),
        .LEN    (LEN),
        .DI     (DI),
        .DO     (DO),
        .DV     (DV)
    );

    always #5 CLK = ~CLK;

    // Backdoor memory read of one word across all bit slices.
    logic [3:0] bd_addr = '0;
    logic [7:0] bd_word;
    for (genvar b = 0; b < 8; b++) begin : g_bd
        assign bd_word[b] = u_dut.g_slice[b].u_ram.mem_q[bd_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         hist[$];
    logic [7:0] shadow[16];
    int         mptr;
    logic [3:0] len_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with given CE/DI; model updates and DV/DO are checked.
    task automatic step(input string tag, input logic ce, input logic [7:0] di);
        int d;
        logic       exp_dv;
        logic [7:0] exp_do;
        CE = ce;
        DI = di;
        @(posedge CLK);
        if (LEN != len_m) begin
            len_m = LEN;
            mptr  = 0;
            hist.delete();
        end else if (ce) begin
            shadow[mptr] = di;
            mptr = (mptr == int'(len_m)) ? 0 : mptr + 1;
            hist.push_back(int'(di));
        end
        #1;
        d      = int'(len_m) + 1 + EXTRA;
        exp_dv = (hist.size() >= d);
        exp_do = exp_dv ? 8'(hist[hist.size() - d]) : 8'h00;
        chk({tag, "_dv"}, 32'(DV), 32'(exp_dv));
        chk({tag, "_do"}, 32'(DO), 32'(exp_do));
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 16; a++) begin
            bd_addr = 4'(a);
            #1;
            chk(tag, {24'h0, bd_word}, {24'h0, shadow[a]});
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) shadow[a] = 8'h00;
        mptr   = 0;
        len_m  = 4'd0;
        RESETN = 1'b0;
        CE     = 1'b0;
        LEN    = 4'd3;
        DI     = 8'h00;

        // Reset state
        #12;
        chk("rst_dv", 32'(DV), 32'h0);
        chk("rst_do", 32'(DO), 32'h0);
        chk("rst_ptr", 32'(u_dut.u_ctrl.ptr_q), 32'h0);
        check_mem("rst_mem_init");
        RESETN = 1'b1;

        // First edge after release is a restart (LEN=3 vs LEN_Q=0): no write even with CE=1.
        step("restart_first", 1'b1, 8'hEE);
        bd_addr = 4'd0;
        #1;
        chk("restart_nowrite", {24'h0, bd_word}, 32'h00);

        // Basic delay LEN=3: DV rises after 4 CE edges, then DO=DI-4.
        for (int k = 1; k <= 10; k++) begin
            step("basic", 1'b1, 8'(k));
            if (k == 3 + EXTRA) chk("basic_dv_low_before_full", 32'(DV), 32'h0);
            if (k == 4 + EXTRA) chk("basic_first_do", 32'(DO), 32'h01);
        end

        // CE gaps, LEN=2: restart edge with CE=0 then alternating CE.
        LEN = 4'd2;
        step("gap_restart", 1'b0, 8'h00);
        for (int k = 1; k <= 14; k++) begin
            step("gap", (k % 2) == 1, 8'(8'h20 + k));
        end

        // Full depth LEN=15, DI=0x00..0x1F, pointer wraps 15->0.
        LEN = 4'd15;
        step("full_restart", 1'b0, 8'h00);
        for (int k = 0; k < 32; k++) begin
            step("full", 1'b1, 8'(k));
            if (k == 14) chk("full_ptr15", 32'(u_dut.u_ctrl.ptr_q), 32'd15);
            if (k == 15) begin
                chk("full_ptr_wrap", 32'(u_dut.u_ctrl.ptr_q), 32'd0);
                if (EXTRA == 0) chk("full_do00_at_di10", 32'(DO), 32'h00);
            end
        end

        // LEN change 3 -> 5 mid-stream.
        LEN = 4'd3;
        step("chg_restart3", 1'b0, 8'h00);
        for (int k = 0; k < 6; k++) step("chg_fill3", 1'b1, 8'(8'h40 + k));
        chk("chg_dv_before", 32'(DV), 32'h1);
        LEN = 4'd5;
        step("chg_edge", 1'b1, 8'h99);
        chk("chg_dv_drop", 32'(DV), 32'h0);
        chk("chg_do_zero", 32'(DO), 32'h0);
        for (int k = 0; k < 8; k++) step("chg_fill5", 1'b1, 8'(8'h50 + k));

        // Async reset mid-stream: outputs clear with no clock edge, memory kept.
        #3;
        RESETN = 1'b0;
        #1;
        chk("arst_dv", 32'(DV), 32'h0);
        chk("arst_do", 32'(DO), 32'h0);
        len_m = 4'd0;
        mptr  = 0;
        hist.delete();
        check_mem("arst_mem_kept");
        RESETN = 1'b1;
        // LEN=5 vs LEN_Q=0 -> restart on first edge, then refill.
        step("post_rst_restart", 1'b1, 8'hAA);
        for (int k = 0; k < 8; k++) step("post_rst", 1'b1, 8'(8'h60 + k));

        // LEN=0: delay of 1 (2 with the output register).
        LEN = 4'd0;
        step("len0_restart", 1'b0, 8'h00);
        step("len0_e1", 1'b1, 8'h71);
        chk("len0_dv_e1", 32'(DV), (EXTRA == 0) ? 32'h1 : 32'h0);
        step("len0_e2", 1'b1, 8'h72);
        chk("len0_dv_e2", 32'(DV), 32'h1);
        for (int k = 0; k < 4; k++) step("len0", (k != 1), 8'(8'h73 + k));
        chk("len0_ptr", 32'(u_dut.u_ctrl.ptr_q), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the bench must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram16_delay_line.md
RAM16_DELAY_LINE -- requirements
Module: ram16_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: data width, i.e. the number of RAM16S1 bit slices instantiated.
REQ-002 Parameter INIT_VAL, default 0 (WIDTH bits): power-up content of every storage word.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 CE  input  1  shift enable; one sample enters and one leaves per CE-high cycle.
REQ-006 LEN  input  4  programmed delay minus one; delay = LEN+1 CE cycles, range 1..16.
REQ-007 DI  input  WIDTH  sample written this CE cycle.
REQ-008 DO  output  WIDTH  delayed sample.
REQ-009 DV  output  1  high once the line holds LEN+1 valid samples; DO is valid only while DV=1.

Function
REQ-010 Storage SHALL be 16 x WIDTH single-port RAM: combinational read, synchronous write, one shared 4-bit address driven by pointer PTR.
REQ-011 On a CE=1 edge, the block SHALL write DI at PTR, then set PTR to 0 if PTR==LEN, else to PTR+1.
REQ-012 The read at PTR SHALL return the old word before the write (read-before-write), so DO equals the DI presented LEN+1 CE cycles earlier.
REQ-013 On a CE=0 edge, PTR, the fill counter, the memory, DV and DO SHALL all hold.
REQ-014 Fill counter FILL (5 bits) SHALL increment on each CE=1 edge and saturate at LEN+1.
REQ-015 DV SHALL be 1 iff FILL==LEN+1 (base configuration).
REQ-016 DO SHALL be forced to 0 whenever DV=0.
REQ-017 LEN SHALL be registered internally as LEN_Q.
REQ-018 If LEN differs from LEN_Q at a clock edge, the block SHALL restart on that edge: LEN_Q<=LEN, PTR<=0, FILL<=0, DV<=0.
REQ-019 During a restart edge the memory write is suppressed, regardless of CE.
REQ-020 LEN=0 SHALL give a delay of 1: PTR stays 0, and DV rises after the first CE cycle.
REQ-021 PTR wrap-around SHALL occur exactly at LEN_Q; PTR never exceeds LEN_Q.

Reset
REQ-022 While RESETN=0, PTR=0, FILL=0, LEN_Q=LEN-at-release is not required, LEN_Q=0, DV=0 and DO=0.
REQ-023 After release, a LEN differing from 0 SHALL trigger a REQ-018 restart on the first edge.
REQ-024 Memory contents SHALL NOT be cleared by reset; they retain the last write or INIT_VAL.
REQ-025 Reset asserted mid-operation SHALL take effect immediately, without waiting for a CLK edge.

Configuration
REQ-026 Macro RAM16_DELAY_OREG_EN, when defined, SHALL add a WIDTH-bit output register and a DV register, both loaded on CE=1 edges.
REQ-027 With RAM16_DELAY_OREG_EN, delay SHALL be LEN+2 CE cycles, and DV SHALL rise one CE cycle later than in the base configuration.
REQ-028 With RAM16_DELAY_OREG_EN, the output registers SHALL reset to 0 and clear on a restart.
REQ-029 Without RAM16_DELAY_OREG_EN, DO SHALL be combinational from the memory read, gated per REQ-016.

Structure
REQ-030 Package ram16_delay_pkg SHALL hold PTR_W=4, FILL_W=5, DEPTH=16 and the maximum delay constant.
REQ-031 The one natural sub-module is ram16_delay_ctrl, holding PTR, FILL, LEN_Q, restart detect and DV.
REQ-032 Storage SHALL be WIDTH instances of RAM16S1 sharing AD=PTR and WRE=CE and not restart.

Verification
REQ-033 Basic delay: LEN=3, CE=1, DI=1,2,3,... -> DV rises after 4 edges; DO=1 on cycle 5, then DO=DI minus 4.
REQ-034 CE gaps: LEN=2, CE toggling 1/0 -> DO advances only on CE cycles, with a delay of exactly 3 CE cycles.
REQ-035 Full depth: LEN=15, DI=0x00..0x1F -> PTR wraps 15->0; DO=0x00 when DI=0x10.
REQ-036 LEN change: LEN 3->5 mid-stream -> DV drops on the same edge, DO=0, and DV returns after 6 CE cycles.
REQ-037 Reset: RESETN pulsed low mid-stream -> DV=0 and DO=0 asynchronously; memory is unchanged, verified via backdoor read.
REQ-038 With RAM16_DELAY_OREG_EN and LEN=0 -> delay is 2 CE cycles, and DV rises on the 2nd CE edge.
